// File: rtl/debounced_inputs_pkg.sv
// debounced_inputs_pkg
// Shared definitions for the debounced_inputs_wb block:
//   - event word field offsets (state, change mask, overflow flag)
//   - maximum supported channel count
//   - bus FSM state type
package debounced_inputs_pkg;

    localparam int STATE_LSB  = 0;
    localparam int MASK_LSB   = 16;
    localparam int OVF_BIT    = 31;
    localparam int MAX_INPUTS = 15;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } bus_state_e;

endpackage

// File: rtl/wishbone_classic.sv
// wishbone_classic
// Minimal Wishbone classic bundle carrying the block clock and reset.
// Modport controller: input clk_i, rst_i, ack_i; output cyc_o, stb_o,
// we_o, adr_o[31:0], dat_o[31:0].
interface wishbone_classic;
    logic        clk_i;
    logic        rst_i;
    logic        cyc_o;
    logic        stb_o;
    logic        we_o;
    logic [31:0] adr_o;
    logic [31:0] dat_o;
    logic        ack_i;

    modport controller (
        input  clk_i,
        input  rst_i,
        input  ack_i,
        output cyc_o,
        output stb_o,
        output we_o,
        output adr_o,
        output dat_o
    );
endinterface

// File: rtl/debounced_inputs_wb_channel.sv
// debounce_channel
// One input channel: SYNC_STAGES-deep synchroniser, restartable stability
// counter and the debounced state bit.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   din         : raw asynchronous pin
//   debounced   : accepted (debounced) level, resets to 0
//   change_stb  : one-cycle pulse, high in the cycle debounced shows a new value
module debounce_channel
    import debounced_inputs_pkg::*;
#(
    parameter int DEBOUNCE_PERIOD = 5_000_000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic debounced,
    output logic change_stb
);
    localparam int CNT_W = $clog2(DEBOUNCE_PERIOD + 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sync_bit;
    logic                   prev_q, prev_d;
    logic                   deb_q, deb_d;
    logic                   stb_q, stb_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    assign sync_bit = sync_q[SYNC_STAGES-1];

    always_comb begin
        // sync_q[0] may go metastable; only the last stage is consumed.
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        prev_d = sync_bit;
        cnt_d  = cnt_q;
        deb_d  = deb_q;
        stb_d  = 1'b0;
        if (sync_bit == deb_q) begin
            cnt_d = '0;
        end else if (sync_bit != prev_q) begin
            // A bounce restarts the stability window at one.
            cnt_d = CNT_W'(1);
        end else if (cnt_q == CNT_W'(DEBOUNCE_PERIOD - 1)) begin
            deb_d = sync_bit;
            cnt_d = '0;
            stb_d = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            cnt_q  <= '0;
            deb_q  <= 1'b0;
            stb_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            cnt_q  <= cnt_d;
            deb_q  <= deb_d;
            stb_q  <= stb_d;
        end
    end

    assign debounced  = deb_q;
    assign change_stb = stb_q;

endmodule

// File: rtl/debounced_inputs_wb.sv
// debounced_inputs_wb
// Debounces N_INPUTS (1..MAX_INPUTS) asynchronous pins, queues every debounced
// change as an event word in a FIFO and drains it as Wishbone classic writes.
// Event word: [N-1:0] new state, [16+N-1:16] change mask, [31] overflow.
// Ports:
//   wb          : Wishbone controller (clk_i, rst_i async active-high, ack_i in;
//                 cyc_o, stb_o, we_o, adr_o, dat_o out)
//   inputs      : raw asynchronous pins
//   debounced   : current debounced state
//   fifo_level  : number of queued events
// Build option: DEBOUNCED_INPUTS_OVF_EN adds a sticky overflow flag that is
// reported in bit 31 of the next event accepted after a drop.
module debounced_inputs_wb
    import debounced_inputs_pkg::*;
#(
    parameter int          N_INPUTS        = 8,
    parameter int          DEBOUNCE_PERIOD = 5_000_000,
    parameter int          SYNC_STAGES     = 2,
    parameter int          FIFO_DEPTH      = 4,
    parameter logic [31:0] WB_ADDR         = 32'h0
) (
    wishbone_classic.controller         wb,
    input  logic [N_INPUTS-1:0]         inputs,
    output logic [N_INPUTS-1:0]         debounced,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic clk;
    logic rst;
    assign clk = wb.clk_i;
    assign rst = wb.rst_i;

    // ---------------------------------------------------------------- channels
    logic [N_INPUTS-1:0] chg_stb;

    for (genvar i = 0; i < N_INPUTS; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_PERIOD (DEBOUNCE_PERIOD),
            .SYNC_STAGES     (SYNC_STAGES)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .din        (inputs[i]),
            .debounced  (debounced[i]),
            .change_stb (chg_stb[i])
        );
    end

    // ---------------------------------------------------------------- FIFO
    logic [31:0]      mem_q [FIFO_DEPTH];
    logic [31:0]      mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [31:0]      evt_word;
    logic             evt_valid;
    logic             full;
    logic             push;
    logic             pop;

    bus_state_e       state_q;
    logic             act_q;
    logic [31:0]      adr_q;
    logic [31:0]      dat_q;

    assign evt_valid = |chg_stb;
    assign full      = (level_q == LVL_W'(FIFO_DEPTH));
    assign pop       = (state_q == BUSY) && wb.ack_i;
    // When full, the entry being popped has already been copied to dat_o,
    // so its slot can take the new event on the same edge.
    assign push      = evt_valid && (!full || pop);

`ifdef DEBOUNCED_INPUTS_OVF_EN
    logic ovf_q, ovf_d;
    logic drop;

    assign drop = evt_valid && !push;

    always_comb begin
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (push) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end
`endif

    always_comb begin
        evt_word                       = '0;
        evt_word[STATE_LSB +: N_INPUTS] = debounced;
        evt_word[MASK_LSB +: N_INPUTS]  = chg_stb;
`ifdef DEBOUNCED_INPUTS_OVF_EN
        evt_word[OVF_BIT]               = ovf_q;
`endif
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = evt_word;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        level_d = level_q + LVL_W'(push) - LVL_W'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                mem_q[k] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // ---------------------------------------------------------------- bus FSM
    // IDLE only looks at the registered level, so after a pop at least one
    // idle cycle passes before the next write starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            act_q   <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (level_q != '0) begin
                        state_q <= BUSY;
                        act_q   <= 1'b1;
                        adr_q   <= WB_ADDR;
                        dat_q   <= mem_q[rd_ptr_q];
                    end
                end
                BUSY: begin
                    if (wb.ack_i) begin
                        state_q <= IDLE;
                        act_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    act_q   <= 1'b0;
                end
            endcase
        end
    end

    assign wb.cyc_o    = act_q;
    assign wb.stb_o    = act_q;
    assign wb.we_o     = act_q;
    assign wb.adr_o    = adr_q;
    assign wb.dat_o    = dat_q;
    assign fifo_level  = level_q;

endmodule

// File: tb/tb_debounced_inputs_wb.sv
// tb_debounced_inputs_wb
// Self-checking bench for debounced_inputs_wb (N=8, period 5, 2 sync stages,
// depth 4). A window-based reference model (an input accepted once its last
// DEBOUNCE_PERIOD synchronised samples agree and differ from the current
// state) plus a queue FIFO is compared every cycle; the Wishbone target
// acknowledges one cycle after stb_o and checks each written word.
module tb_debounced_inputs_wb;

    localparam int          N    = 8;
    localparam int          P    = 5;
    localparam int          S    = 2;
    localparam int          D    = 4;
    localparam logic [31:0] ADDR = 32'h0000_1000;
`ifdef DEBOUNCED_INPUTS_OVF_EN
    localparam logic [31:0] OVF_EXP = 32'h8004_0000;
`else
    localparam logic [31:0] OVF_EXP = 32'h0004_0000;
`endif

    wishbone_classic wb_if ();
    logic [N-1:0] inputs;
    logic [N-1:0] debounced;
    logic [2:0]   fifo_level;

    debounced_inputs_wb #(
        .N_INPUTS        (N),
        .DEBOUNCE_PERIOD (P),
        .SYNC_STAGES     (S),
        .FIFO_DEPTH      (D),
        .WB_ADDR         (ADDR)
    ) dut (
        .wb         (wb_if),
        .inputs     (inputs),
        .debounced  (debounced),
        .fifo_level (fifo_level)
    );

    initial begin
        wb_if.clk_i = 1'b0;
        forever #5 wb_if.clk_i = ~wb_if.clk_i;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------ reference model
    logic [N-1:0] m_samp [S];   // [0] newest raw sample
    logic [N-1:0] m_hist [P];   // [0] newest synchronised value
    logic [N-1:0] m_deb;
    logic [31:0]  m_q [$];
    logic         m_pend;
    logic [31:0]  m_pend_w;
    logic         m_ovf;

    task automatic m_reset();
        for (int k = 0; k < S; k++) m_samp[k] = '0;
        for (int k = 0; k < P; k++) m_hist[k] = '0;
        m_deb = '0; m_q.delete(); m_pend = 1'b0; m_pend_w = '0; m_ovf = 1'b0;
    endtask

    task automatic m_step();
        logic         acc;
        logic [31:0]  w;
        logic [N-1:0] mask;
        logic         same;
        if (wb_if.rst_i) begin
            m_reset();
            return;
        end
        acc = m_pend && (m_q.size() < D || wb_if.ack_i);
        if (wb_if.ack_i && m_q.size() > 0) void'(m_q.pop_front());
        w = m_pend_w;
`ifdef DEBOUNCED_INPUTS_OVF_EN
        w[31] = m_ovf;
`endif
        if (acc) begin
            m_q.push_back(w);
            m_ovf = 1'b0;
        end else if (m_pend) begin
            m_ovf = 1'b1;
        end
        for (int k = P - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = m_samp[S-1];
        mask = '0;
        for (int b = 0; b < N; b++) begin
            same = 1'b1;
            for (int k = 1; k < P; k++) if (m_hist[k][b] != m_hist[0][b]) same = 1'b0;
            if (same && m_hist[0][b] != m_deb[b]) mask[b] = 1'b1;
        end
        m_deb    = m_deb ^ mask;
        m_pend   = |mask;
        m_pend_w = {8'h00, mask, 8'h00, m_deb};
        for (int k = S - 1; k > 0; k--) m_samp[k] = m_samp[k-1];
        m_samp[0] = inputs;
    endtask

    // ------------------------------------------------------------ cycle driver
    logic        ack_en;
    int          stb_seen;
    int          idle_pend;
    int          n_writes;
    logic [31:0] last_dat;

    task automatic tick();
        logic new_ack;
        @(posedge wb_if.clk_i);
        m_step();
        @(negedge wb_if.clk_i);
        chk("debounced", {24'h0, debounced}, {24'h0, m_deb});
        chk("fifo_level", {29'h0, fifo_level}, m_q.size());
        if (wb_if.ack_i) chk("idle_gap_after_ack", {31'h0, wb_if.cyc_o}, 32'h0);
        if (wb_if.cyc_o) begin
            chk("bus_ctrl", {29'h0, wb_if.cyc_o, wb_if.stb_o, wb_if.we_o}, 32'h7);
            chk("bus_adr", wb_if.adr_o, ADDR);
        end
        if (m_q.size() > 0 && !wb_if.cyc_o && !wb_if.rst_i) begin
            idle_pend++;
            chk("write_start_latency", idle_pend, 1);
        end else begin
            idle_pend = 0;
        end
        // Target: acknowledge on the second cycle stb_o is seen high.
        stb_seen = wb_if.stb_o ? stb_seen + 1 : 0;
        new_ack  = ack_en && wb_if.stb_o && (stb_seen >= 2) && !wb_if.ack_i;
        wb_if.ack_i = new_ack;
        if (new_ack) begin
            chk("write_expected", {31'h0, m_q.size() > 0}, 32'h1);
            if (m_q.size() > 0) chk("write_data", wb_if.dat_o, m_q[0]);
            n_writes++;
            last_dat = wb_if.dat_o;
        end
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    typedef struct {
        logic [7:0]  in;
        int          hold;
        logic [7:0]  exp_deb;
        int          exp_wr;
        logic [31:0] exp_dat;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int w0;
        tbl[0] = '{8'h00, 20, 8'h00, 1, 32'h0003_0000};
        tbl[1] = '{8'h10, 4,  8'h00, 0, 32'h0};
        tbl[2] = '{8'h00, 20, 8'h00, 0, 32'h0};
        tbl[3] = '{8'h42, 20, 8'h42, 1, 32'h0042_0042};
        tbl[4] = '{8'h40, 20, 8'h40, 1, 32'h0002_0040};
        tbl[5] = '{8'h00, 20, 8'h00, 1, 32'h0040_0000};

        ack_en = 1'b1; stb_seen = 0; idle_pend = 0; n_writes = 0; last_dat = '0;
        inputs = '0; wb_if.ack_i = 1'b0; wb_if.rst_i = 1'b1;
        m_reset();
        #3;
        chk("rst_cyc", {31'h0, wb_if.cyc_o}, 32'h0);
        chk("rst_stb_we", {30'h0, wb_if.stb_o, wb_if.we_o}, 32'h0);
        chk("rst_adr", wb_if.adr_o, 32'h0);
        chk("rst_dat", wb_if.dat_o, 32'h0);
        chk("rst_debounced", {24'h0, debounced}, 32'h0);
        chk("rst_fifo_level", {29'h0, fifo_level}, 32'h0);
        ticks(2);
        wb_if.rst_i = 1'b0;

        // Exact latency: 0x00 -> 0x03.
        inputs = 8'h03;
        ticks(6);
        chk("lat_deb_before", {24'h0, debounced}, 32'h0);
        tick();
        chk("lat_deb_at7", {24'h0, debounced}, 32'h3);
        chk("lat_level_at7", {29'h0, fifo_level}, 32'h0);
        tick();
        chk("lat_level_at8", {29'h0, fifo_level}, 32'h1);
        chk("lat_cyc_at8", {31'h0, wb_if.cyc_o}, 32'h0);
        tick();
        chk("lat_cyc_at9", {31'h0, wb_if.cyc_o}, 32'h1);
        ticks(6);
        chk("lat_writes", n_writes, 1);
        chk("lat_dat", last_dat, 32'h0003_0003);

        // Table vectors.
        for (int v = 0; v < 6; v++) begin
            w0 = n_writes;
            inputs = tbl[v].in;
            ticks(tbl[v].hold);
            chk($sformatf("tbl%0d_deb", v), {24'h0, debounced}, {24'h0, tbl[v].exp_deb});
            chk($sformatf("tbl%0d_writes", v), n_writes - w0, tbl[v].exp_wr);
            if (tbl[v].exp_wr > 0) chk($sformatf("tbl%0d_dat", v), last_dat, tbl[v].exp_dat);
        end

        // Bounce on bit 0, then hold high.
        w0 = n_writes;
        for (int t = 0; t < 10; t++) begin
            inputs = ((t / 2) % 2 == 0) ? 8'h01 : 8'h00;
            tick();
        end
        ticks(4);
        chk("bounce_deb_before", {24'h0, debounced}, 32'h0);
        tick();
        chk("bounce_deb_at7", {24'h0, debounced}, 32'h1);
        chk("bounce_no_early_write", n_writes - w0, 0);
        ticks(10);
        chk("bounce_writes", n_writes - w0, 1);
        chk("bounce_dat", last_dat, 32'h0001_0001);
        inputs = 8'h00;
        ticks(20);

        // Overflow: 5 events with the target stalled.
        ack_en = 1'b0;
        for (int e = 0; e < 5; e++) begin
            inputs[2] = ~inputs[2];
            ticks(10);
        end
        chk("ovf_level_sat", {29'h0, fifo_level}, 32'h4);
        w0 = n_writes;
        ack_en = 1'b1;
        ticks(30);
        chk("ovf_drain_writes", n_writes - w0, 4);
        chk("ovf_drain_level", {29'h0, fifo_level}, 32'h0);
        inputs[2] = 1'b0;
        ticks(20);
        chk("ovf_flag_written", last_dat, OVF_EXP);
        inputs[2] = 1'b1;
        ticks(20);
        chk("ovf_flag_cleared", last_dat, 32'h0004_0004);

        // Reset in the middle of a write.
        ack_en = 1'b0;
        inputs = 8'h05;
        ticks(12);
        chk("mid_cyc_high", {31'h0, wb_if.cyc_o}, 32'h1);
        #2;
        wb_if.rst_i = 1'b1;
        #1;
        chk("mid_rst_cyc", {31'h0, wb_if.cyc_o}, 32'h0);
        chk("mid_rst_stb", {31'h0, wb_if.stb_o}, 32'h0);
        chk("mid_rst_level", {29'h0, fifo_level}, 32'h0);
        chk("mid_rst_deb", {24'h0, debounced}, 32'h0);
        m_reset();
        wb_if.ack_i = 1'b0; stb_seen = 0;
        ticks(2);
        wb_if.rst_i = 1'b0;
        ack_en = 1'b1;
        w0 = n_writes;
        ticks(6);
        chk("post_rst_deb_before", {24'h0, debounced}, 32'h0);
        tick();
        chk("post_rst_deb_at7", {24'h0, debounced}, 32'h5);
        chk("post_rst_no_write", n_writes - w0, 0);
        ticks(15);
        chk("post_rst_writes", n_writes - w0, 1);
        chk("post_rst_dat", last_dat, 32'h0005_0005);

        // Randomised traffic against the model.
        for (int s = 0; s < 300; s++) begin
            inputs = inputs ^ 8'($urandom & $urandom);
            if ($urandom_range(0, 9) == 0) ack_en = ~ack_en;
            ticks($urandom_range(1, 9));
        end
        ack_en = 1'b1;
        ticks(60);
        chk("final_drain", {29'h0, fifo_level}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
